// File: rtl/if_fetch_queue.sv
// Generic synchronous FIFO with a synchronous flush, used as the fetch prefetch buffer.
// Latency: a push is visible at the head on the cycle after it is written; the head reads combinationally.
// Backpressure: push_rdy drops when full and pop_vld drops when empty; flush wins over push and pop in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push_vld,
    output logic                       push_rdy,
    input  logic [WIDTH-1:0]           push_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (cnt != CW'(DEPTH));
    assign pop_vld  = (cnt != '0);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_vld & pop_rdy;
    assign pop_dat  = mem[rd_ptr];
    assign count    = cnt;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array: data only, no reset needed because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// Instruction fetch stage: sequential PC generation, 1-cycle imem access, DEPTH-entry prefetch queue to decode.
// Latency: request in C0, data returns in C1 and is enqueued at its end, out_valid in C2; 1 instr/cycle sustained.
// Backpressure: a fetch issues only when queue + in-flight - dequeue leaves room; redirect flushes queue and kills in-flight.
module if_fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     imem_req,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  inflight;

    logic                  deq;
    logic                  enq;
    logic                  fifo_push_rdy;
    logic [CW:0]           pending;
    logic                  credit_ok;
    entry_t                enq_dat;
    entry_t                head_dat;

    // Decode consumes the head this cycle.
    assign deq = out_valid & out_ready;

    // Slots committed after this edge: queued entries plus the returning fetch, minus the one leaving.
    // One extra bit keeps count + inflight from wrapping when the queue is full.
    assign pending   = {1'b0, queue_count} + (CW + 1)'(inflight) - (CW + 1)'(deq);
    assign credit_ok = (pending < (CW + 1)'(DEPTH));

    // No fetch while held in reset or while a redirect replaces the PC.
    assign imem_req  = reset_n & ~redirect_valid & credit_ok;
    assign imem_addr = fetch_pc;

    // A response returning in a redirect cycle belongs to the wrong path and is dropped.
    assign enq           = inflight & ~redirect_valid;
    assign enq_dat.pc    = req_pc;
    assign enq_dat.instr = imem_rdata;

    // PC generation and in-flight tracking; a redirect overrides any request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push_vld (enq & fifo_push_rdy),
        .push_rdy (fifo_push_rdy),
        .push_dat (enq_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat),
        .count    (queue_count)
    );

    assign out_pc    = head_dat.pc;
    assign out_instr = head_dat.instr;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  queue_count;

    int errors = 0;
    int checks = 0;
    int m_errors = 0;
    int m_checks = 0;

    logic [31:0] exp_pc [64];
    int          exp_wr = 0;
    int          m_rd = 0;

    if_fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0),
        .PC_STEP    (32'h4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {8'hA5, pc[23:0]};
    endfunction

    // Synchronous instruction memory: data appears the cycle after an accepted request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word_of(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    // Monitor: every accepted output is compared against the next expected pc/instruction.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (m_rd >= exp_wr) begin
                m_checks++;
                m_errors++;
                $display("FAIL unexpected_out: got pc=%0h, required no delivery", out_pc);
            end else begin
                m_checks++;
                if (out_pc !== exp_pc[m_rd]) begin
                    m_errors++;
                    $display("FAIL out_pc[%0d]: got %0h, required %0h", m_rd, out_pc, exp_pc[m_rd]);
                end
                m_checks++;
                if (out_instr !== word_of(exp_pc[m_rd])) begin
                    m_errors++;
                    $display("FAIL out_instr[%0d]: got %0h, required %0h", m_rd, out_instr, word_of(exp_pc[m_rd]));
                end
                m_rd++;
            end
        end
    end

    task automatic push(input logic [31:0] pc);
        exp_pc[exp_wr] = pc;
        exp_wr++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i <= 10; i++) push(32'(4 * i));

        // Reset state
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);

        // Streaming from reset with decode always ready
        next_cycle();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("A_req", imem_req, 1);
            chk("A_addr", imem_addr, 64'(4 * k));
            chk("A_valid", out_valid, 64'(k >= 2));
            next_cycle();
        end

        // Decode stalls for 10 cycles: queue fills to 4, fetch stops, head holds
        out_ready = 1'b0;
        for (int k = 6; k < 16; k++) begin
            @(negedge clk);
            chk("B_req", imem_req, 64'(k < 8));
            chk("B_count", queue_count, (k == 6) ? 1 : (k == 7) ? 2 : (k == 8) ? 3 : 4);
            chk("B_head", out_pc, 32'h10);
            chk("B_addr", imem_addr, (k < 8) ? 64'(4 * k) : 64'h20);
            next_cycle();
        end

        // Ready again from a full queue: requests continuous, occupancy steady
        out_ready = 1'b1;
        for (int k = 16; k < 22; k++) begin
            @(negedge clk);
            chk("C_req", imem_req, 1);
            chk("C_count", queue_count, (k == 16) ? 4 : 3);
            chk("C_addr", imem_addr, 64'(32 + 4 * (k - 16)));
            next_cycle();
        end

        // Redirect with 3 queued, one in flight, and a dequeue of pc 0x28 in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        push(32'h100); push(32'h104); push(32'h108);
        @(negedge clk);
        chk("D_req_redirect", imem_req, 0);
        chk("D_count_before", queue_count, 3);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("D_count_flushed", queue_count, 0);
        chk("D_valid_flushed", out_valid, 0);
        chk("D_req_target", imem_req, 1);
        chk("D_addr_target", imem_addr, 32'h100);
        next_cycle();
        @(negedge clk);
        chk("D_valid_wait", out_valid, 0);
        chk("D_addr_next", imem_addr, 32'h104);
        next_cycle();
        @(negedge clk);
        chk("D_valid_first", out_valid, 1);
        chk("D_pc_first", out_pc, 32'h100);
        chk("D_count_first", queue_count, 1);
        next_cycle();
        next_cycle();
        next_cycle();

        // Back-to-back redirects while decode stalls: only the last target is fetched
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        chk("E_req_r1", imem_req, 0);
        chk("E_head_r1", out_pc, 32'h10C);
        next_cycle();
        redirect_pc = 32'h300;
        push(32'h300); push(32'h304); push(32'h308); push(32'h30C);
        @(negedge clk);
        chk("E_count_r2", queue_count, 0);
        chk("E_req_r2", imem_req, 0);
        chk("E_addr_r2", imem_addr, 32'h200);
        chk("E_valid_r2", out_valid, 0);
        next_cycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        chk("E_req_last", imem_req, 1);
        chk("E_addr_last", imem_addr, 32'h300);
        next_cycle();
        @(negedge clk);
        chk("E_valid_wait", out_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("E_pc_first", out_pc, 32'h300);
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();

        // Asynchronous reset between edges, with data in the queue and a fetch in flight
        #2;
        reset_n = 1'b0;
        push(32'h0); push(32'h4); push(32'h8);
        #1;
        chk("F_rst_valid", out_valid, 0);
        chk("F_rst_count", queue_count, 0);
        chk("F_rst_req", imem_req, 0);
        chk("F_rst_addr", imem_addr, 0);
        @(negedge clk);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("F_req_restart", imem_req, 1);
        chk("F_addr_restart", imem_addr, 0);
        chk("F_valid_restart", out_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("F_addr_next", imem_addr, 4);
        chk("F_valid_wait", out_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("F_pc_first", out_pc, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        chk("F_head_end", out_pc, 32'hC);
        chk("all_delivered", 64'(m_rd), 64'(exp_wr));

        errors = errors + m_errors;
        checks = checks + m_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
